// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary encoder decoder: idle input level,
// quadrature code points and detent-tracking FSM state encoding.
package rotary_pkg;

  // Encoder channels and push switch rest high through pull-ups.
  localparam logic IDLE_LEVEL = 1'b1;

  // Stable {A,B} code points of one quadrature cycle.
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_10 = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CW1  = 3'd1,
    ST_CW2  = 3'd2,
    ST_CW3  = 3'd3,
    ST_CCW1 = 3'd4,
    ST_CCW2 = 3'd5,
    ST_CCW3 = 3'd6
  } rot_state_e;

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a consecutive-cycle debouncer for one
// asynchronous input; the debounced level only moves after a stable run.
module debouncer
  import rotary_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 40000,
  parameter logic        RESET_VAL       = IDLE_LEVEL
) (
  input  logic clk,
  input  logic res,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing cycles; accept the new level on the last one.
  always_comb begin
    sync_d   = {sync_q[0], din};
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      sync_q   <= {2{RESET_VAL}};
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/rotary_decoder.sv
// Rotary encoder front end: debounces A, B and the push switch, then turns
// full quadrature detents into rot_up/rot_dn pulses and presses into push.
module rotary_decoder
  import rotary_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 40000
) (
  input  logic clk,
  input  logic res,
  input  logic enc_a,
  input  logic enc_b,
  input  logic enc_sw,
  output logic rot_up,
  output logic rot_dn,
  output logic push
);

  logic       a_stable, b_stable, sw_stable;
  logic [1:0] ab;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(IDLE_LEVEL)) u_deb_a (
    .clk (clk),
    .res (res),
    .din (enc_a),
    .dout(a_stable)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(IDLE_LEVEL)) u_deb_b (
    .clk (clk),
    .res (res),
    .din (enc_b),
    .dout(b_stable)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(IDLE_LEVEL)) u_deb_sw (
    .clk (clk),
    .res (res),
    .din (enc_sw),
    .dout(sw_stable)
  );

  assign ab = {a_stable, b_stable};

  rot_state_e state_q, state_d;
  logic       rot_up_q, rot_up_d;
  logic       rot_dn_q, rot_dn_d;
  logic       push_q, push_d;
  logic       sw_prev_q, sw_prev_d;

  // Detent tracker: a pulse fires only when a full cycle returns to 11.
  always_comb begin
    state_d  = state_q;
    rot_up_d = 1'b0;
    rot_dn_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ab == AB_01) begin
          state_d = ST_CW1;
        end else if (ab == AB_10) begin
          state_d = ST_CCW1;
        end
      end
      ST_CW1: begin
        case (ab)
          AB_00:   state_d = ST_CW2;
          AB_11:   state_d = ST_IDLE;
          AB_10:   state_d = ST_IDLE;
          default: state_d = ST_CW1;
        endcase
      end
      ST_CW2: begin
        case (ab)
          AB_10:   state_d = ST_CW3;
          AB_01:   state_d = ST_CW1;
          AB_11:   state_d = ST_IDLE;
          default: state_d = ST_CW2;
        endcase
      end
      ST_CW3: begin
        case (ab)
          AB_11: begin
            state_d  = ST_IDLE;
            rot_up_d = 1'b1;
          end
          AB_00:   state_d = ST_CW2;
          AB_01:   state_d = ST_IDLE;
          default: state_d = ST_CW3;
        endcase
      end
      ST_CCW1: begin
        case (ab)
          AB_00:   state_d = ST_CCW2;
          AB_11:   state_d = ST_IDLE;
          AB_01:   state_d = ST_IDLE;
          default: state_d = ST_CCW1;
        endcase
      end
      ST_CCW2: begin
        case (ab)
          AB_01:   state_d = ST_CCW3;
          AB_10:   state_d = ST_CCW1;
          AB_11:   state_d = ST_IDLE;
          default: state_d = ST_CCW2;
        endcase
      end
      ST_CCW3: begin
        case (ab)
          AB_11: begin
            state_d  = ST_IDLE;
            rot_dn_d = 1'b1;
          end
          AB_00:   state_d = ST_CCW2;
          AB_10:   state_d = ST_IDLE;
          default: state_d = ST_CCW3;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Press edge: debounced switch falling from released to pressed.
  always_comb begin
    sw_prev_d = sw_stable;
    push_d    = sw_prev_q & ~sw_stable;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= ST_IDLE;
      rot_up_q  <= 1'b0;
      rot_dn_q  <= 1'b0;
      push_q    <= 1'b0;
      sw_prev_q <= IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      rot_up_q  <= rot_up_d;
      rot_dn_q  <= rot_dn_d;
      push_q    <= push_d;
      sw_prev_q <= sw_prev_d;
    end
  end

  assign rot_up = rot_up_q;
  assign rot_dn = rot_dn_q;
  assign push   = push_q;

endmodule

// File: tb/tb_rotary_decoder.sv
// Bench for rotary_decoder: directed scenarios plus random encoder activity,
// every cycle compared against a positional quadrature reference model.
module tb_rotary_decoder;
  import rotary_pkg::*;

  localparam int N = 4;

  logic clk;
  logic res;
  logic enc_a;
  logic enc_b;
  logic enc_sw;
  logic rot_up;
  logic rot_dn;
  logic push;

  rotary_decoder #(.DEBOUNCE_CYCLES(N)) dut (
    .clk   (clk),
    .res   (res),
    .enc_a (enc_a),
    .enc_b (enc_b),
    .enc_sw(enc_sw),
    .rot_up(rot_up),
    .rot_dn(rot_dn),
    .push  (push)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: input delay line, window-based debounce, signed position.
  logic [2:0] m_s1, m_s2, m_stab;
  logic [2:0] hist[$];
  logic       m_prev_sw;
  int         m_d;
  logic       m_up, m_dn, m_push;

  int cyc = 0;
  int n_up, n_dn, n_push;
  int up_cyc, dn_cyc, push_cyc;
  int mark;

  logic [1:0] gray [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
  int   pos;
  int   rnd;
  int   len;
  logic sw_r;
  logic rst_r;

  function automatic int phase_of(input logic [1:0] ab);
    case (ab)
      2'b11:   return 0;
      2'b01:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_edge(input logic a, input logic b, input logic sw, input logic r);
    int   delta;
    logic all_diff;
    if (r) begin
      m_s1 = 3'b111;
      m_s2 = 3'b111;
      m_stab = 3'b111;
      m_prev_sw = 1'b1;
      m_d = 0;
      hist.delete();
      m_up = 1'b0;
      m_dn = 1'b0;
      m_push = 1'b0;
    end else begin
      m_up = 1'b0;
      m_dn = 1'b0;
      if (m_stab[2:1] == 2'b11) begin
        if (m_d == 3)  m_up = 1'b1;
        if (m_d == -3) m_dn = 1'b1;
        m_d = 0;
      end else if (m_d == 0) begin
        if (m_stab[2:1] == 2'b01)      m_d = 1;
        else if (m_stab[2:1] == 2'b10) m_d = -1;
      end else begin
        delta = (phase_of(m_stab[2:1]) - ((m_d + 4) % 4) + 4) % 4;
        if (delta == 1)      m_d = m_d + 1;
        else if (delta == 3) m_d = m_d - 1;
        else if (delta == 2) m_d = 0;
      end
      m_push = m_prev_sw & ~m_stab[0];
      m_prev_sw = m_stab[0];
      hist.push_back(m_s2);
      if (hist.size() > N) void'(hist.pop_front());
      if (hist.size() == N) begin
        for (int ch = 0; ch < 3; ch++) begin
          all_diff = 1'b1;
          for (int i = 0; i < N; i++) begin
            if (hist[i][ch] == m_stab[ch]) all_diff = 1'b0;
          end
          if (all_diff) m_stab[ch] = ~m_stab[ch];
        end
      end
      m_s2 = m_s1;
      m_s1 = {a, b, sw};
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_counts();
    n_up = 0;
    n_dn = 0;
    n_push = 0;
    up_cyc = -1;
    dn_cyc = -1;
    push_cyc = -1;
  endtask

  task automatic step(input logic a, input logic b, input logic sw, input logic r);
    enc_a = a;
    enc_b = b;
    enc_sw = sw;
    res = r;
    @(posedge clk);
    model_edge(a, b, sw, r);
    #1;
    cyc++;
    chk("rot_up", rot_up, m_up);
    chk("rot_dn", rot_dn, m_dn);
    chk("push", push, m_push);
    chk("up_dn_exclusive", rot_up & rot_dn, 1'b0);
    n_up += int'(rot_up);
    n_dn += int'(rot_dn);
    n_push += int'(push);
    if (rot_up && up_cyc < 0) up_cyc = cyc;
    if (rot_dn && dn_cyc < 0) dn_cyc = cyc;
    if (push && push_cyc < 0) push_cyc = cyc;
  endtask

  task automatic hold(input logic [1:0] ab, input logic sw, input int n);
    repeat (n) step(ab[1], ab[0], sw, 1'b0);
  endtask

  initial begin
    m_up = 1'b0;
    m_dn = 1'b0;
    m_push = 1'b0;
    clear_counts();
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_rot_up", rot_up, 1'b0);
    chk("reset_rot_dn", rot_dn, 1'b0);
    chk("reset_push", push, 1'b0);
    chk_int("reset_state", int'(dut.state_q), int'(ST_IDLE));
    hold(2'b11, 1'b1, 10);

    // Clean clockwise detent
    clear_counts();
    hold(2'b01, 1'b1, 10);
    hold(2'b00, 1'b1, 10);
    hold(2'b10, 1'b1, 10);
    mark = cyc;
    hold(2'b11, 1'b1, 10);
    chk_int("cw_up_count", n_up, 1);
    chk_int("cw_dn_count", n_dn, 0);
    chk_int("cw_latency", up_cyc - mark, 7);

    // Clean counter-clockwise detent
    clear_counts();
    hold(2'b10, 1'b1, 10);
    hold(2'b00, 1'b1, 10);
    hold(2'b01, 1'b1, 10);
    mark = cyc;
    hold(2'b11, 1'b1, 10);
    chk_int("ccw_dn_count", n_dn, 1);
    chk_int("ccw_up_count", n_up, 0);
    chk_int("ccw_latency", dn_cyc - mark, 7);

    // Bounce on A shorter than the debounce window
    clear_counts();
    repeat (5) begin
      repeat (2) begin
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk_int("bounce_state", int'(dut.state_q), int'(ST_IDLE));
      end
      repeat (2) begin
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk_int("bounce_state", int'(dut.state_q), int'(ST_IDLE));
      end
    end
    hold(2'b11, 1'b1, 10);
    chk_int("bounce_pulses", n_up + n_dn + n_push, 0);
    chk_int("bounce_state_end", int'(dut.state_q), int'(ST_IDLE));

    // Partial clockwise turn that reverses
    clear_counts();
    hold(2'b01, 1'b1, 10);
    hold(2'b00, 1'b1, 10);
    hold(2'b01, 1'b1, 10);
    hold(2'b11, 1'b1, 10);
    chk_int("reversal_pulses", n_up + n_dn, 0);

    // Press then release
    clear_counts();
    mark = cyc;
    hold(2'b11, 1'b0, 20);
    hold(2'b11, 1'b1, 20);
    chk_int("push_count", n_push, 1);
    chk_int("push_latency", push_cyc - mark, 7);

    // Reset while waiting in CW3 aborts the detent
    clear_counts();
    hold(2'b01, 1'b1, 10);
    hold(2'b00, 1'b1, 10);
    hold(2'b10, 1'b1, 10);
    chk_int("in_cw3", int'(dut.state_q), int'(ST_CW3));
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1);
    chk_int("reset_abort_state", int'(dut.state_q), int'(ST_IDLE));
    hold(2'b11, 1'b1, 20);
    chk_int("reset_abort_pulses", n_up + n_dn + n_push, 0);

    // Switch held pressed across reset release
    clear_counts();
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1);
    mark = cyc;
    hold(2'b11, 1'b0, 20);
    hold(2'b11, 1'b1, 20);
    chk_int("held_push_count", n_push, 1);
    chk_int("held_push_latency", push_cyc - mark, 7);

    // Random turns, bounces, double steps, presses and occasional resets
    pos = 0;
    sw_r = 1'b1;
    for (int it = 0; it < 400; it++) begin
      rnd = int'($urandom_range(0, 99));
      len = int'($urandom_range(1, 12));
      if (rnd < 40)      pos = (pos + 1) % 4;
      else if (rnd < 75) pos = (pos + 3) % 4;
      else if (rnd < 80) pos = (pos + 2) % 4;
      if ($urandom_range(0, 9) == 0) sw_r = ~sw_r;
      rst_r = (rnd >= 98);
      repeat (len) step(gray[pos][1], gray[pos][0], sw_r, rst_r);
    end
    hold(2'b11, 1'b1, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
